// File: rtl/player_input_ctrl.sv
// player_input_ctrl: per-player movement intent (direction, facing, walk speed,
// jump thrust) advanced only on the per-frame tick so key chatter between
// frames never reaches the physics block.
module player_input_ctrl #(
  parameter int unsigned MAX_SPEED    = 4,
  parameter int unsigned SPD_W        = 3,
  parameter int unsigned ACCEL_FRAMES = 4,
  parameter int unsigned MAX_HOLD     = 12
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_tick,
  input  logic             key_up,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             grounded,
  output logic [1:0]       move_dir,
  output logic             facing,
  output logic [SPD_W-1:0] speed,
  output logic             jump_start,
  output logic             jump_hold
);

  localparam int unsigned CNT_W  = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(ACCEL_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [SPD_W-1:0]  SPD_MAX   = SPD_W'(MAX_SPEED);
  localparam logic [SPD_W-1:0]  SPD_ONE   = SPD_W'(1);

  typedef enum logic [1:0] {
    D_NONE  = 2'b00,
    D_LEFT  = 2'b01,
    D_RIGHT = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    J_IDLE,
    J_HOLD,
    J_RELEASE
  } jump_e;

  dir_e              dir_q, dir_d;
  logic              left_prev_q, left_prev_d;
  logic              right_prev_q, right_prev_d;
  logic              up_prev_q, up_prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SPD_W-1:0]  speed_q, speed_d;
  logic              facing_q, facing_d;
  jump_e             jst_q, jst_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              jump_start_q, jump_start_d;
  logic              jump_hold_q, jump_hold_d;

  logic left_new, right_new, up_rise;
  logic dir_chg, cnt_wrap, step_ok, dir_aligned;

  assign left_new    = key_left & ~left_prev_q;
  assign right_new   = key_right & ~right_prev_q;
  assign up_rise     = key_up & ~up_prev_q;
  assign dir_chg     = (dir_d != dir_q);
  assign cnt_wrap    = (cnt_q == CNT_LAST);
  assign step_ok     = cnt_wrap & ~dir_chg;
  assign dir_aligned = ((dir_d == D_LEFT) == facing_q);

  assign move_dir   = dir_q;
  assign facing     = facing_q;
  assign speed      = speed_q;
  assign jump_start = jump_start_q;
  assign jump_hold  = jump_hold_q;

  // Direction resolution: most recently pressed key wins while both are held.
  always_comb begin
    dir_d        = dir_q;
    left_prev_d  = left_prev_q;
    right_prev_d = right_prev_q;
    if (frame_tick) begin
      left_prev_d  = key_left;
      right_prev_d = key_right;
      case ({key_left, key_right})
        2'b10: dir_d = D_LEFT;
        2'b01: dir_d = D_RIGHT;
        2'b11: begin
          if (left_new && !right_new) begin
            dir_d = D_LEFT;
          end else if (right_new && !left_new) begin
            dir_d = D_RIGHT;
          end else if (dir_q == D_NONE) begin
            dir_d = D_RIGHT;
          end
        end
        default: dir_d = D_NONE;
      endcase
    end
  end

  // Speed ramp, friction and skid; facing only turns once the sprite is stopped.
  always_comb begin
    cnt_d    = cnt_q;
    speed_d  = speed_q;
    facing_d = facing_q;
    if (frame_tick) begin
      cnt_d = (dir_chg || cnt_wrap) ? '0 : cnt_q + CNT_W'(1);
      if (dir_d == D_NONE) begin
        if (step_ok && speed_q != '0) speed_d = speed_q - SPD_ONE;
      end else if (dir_aligned) begin
        if (step_ok && speed_q < SPD_MAX) speed_d = speed_q + SPD_ONE;
      end else begin
        // Skid: the tick that brings speed to zero also turns the sprite and
        // restarts the acceleration period from zero.
        if (speed_q > SPD_ONE) begin
          speed_d = speed_q - SPD_ONE;
        end else begin
          speed_d  = '0;
          facing_d = (dir_d == D_LEFT);
          cnt_d    = '0;
        end
      end
    end
  end

  // Jump control: edge-triggered start on the ground, bounded thrust, re-arm on landing.
  always_comb begin
    jst_d        = jst_q;
    hold_cnt_d   = hold_cnt_q;
    jump_hold_d  = jump_hold_q;
    up_prev_d    = up_prev_q;
    jump_start_d = 1'b0;
    if (frame_tick) begin
      up_prev_d = key_up;
      case (jst_q)
        J_IDLE: begin
          if (up_rise && grounded) begin
            jump_start_d = 1'b1;
            jump_hold_d  = 1'b1;
            hold_cnt_d   = '0;
            jst_d        = J_HOLD;
          end
        end
        J_HOLD: begin
          if (!key_up || hold_cnt_q == HOLD_LAST) begin
            jump_hold_d = 1'b0;
            jst_d       = J_RELEASE;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        J_RELEASE: begin
          if (!key_up && grounded) jst_d = J_IDLE;
        end
        default: begin
          jst_d       = J_IDLE;
          jump_hold_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dir_q        <= D_NONE;
      left_prev_q  <= 1'b0;
      right_prev_q <= 1'b0;
      // Treat the jump key as already held so a key kept down through reset
      // must be released and pressed again before it can start a jump.
      up_prev_q    <= 1'b1;
      cnt_q        <= '0;
      speed_q      <= '0;
      facing_q     <= 1'b0;
      jst_q        <= J_IDLE;
      hold_cnt_q   <= '0;
      jump_start_q <= 1'b0;
      jump_hold_q  <= 1'b0;
    end else begin
      dir_q        <= dir_d;
      left_prev_q  <= left_prev_d;
      right_prev_q <= right_prev_d;
      up_prev_q    <= up_prev_d;
      cnt_q        <= cnt_d;
      speed_q      <= speed_d;
      facing_q     <= facing_d;
      jst_q        <= jst_d;
      hold_cnt_q   <= hold_cnt_d;
      jump_start_q <= jump_start_d;
      jump_hold_q  <= jump_hold_d;
    end
  end

endmodule
